// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register offsets, bus width
// and the address decoder used by the register file.
package gpio_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] OFF_OUT      = 32'h00;
    localparam logic [DATA_W-1:0] OFF_DIR      = 32'h04;
    localparam logic [DATA_W-1:0] OFF_IN       = 32'h08;
    localparam logic [DATA_W-1:0] OFF_IRQ_EN   = 32'h0C;
    localparam logic [DATA_W-1:0] OFF_IRQ_STAT = 32'h10;
    localparam logic [DATA_W-1:0] OFF_EDGE_SEL = 32'h14;

    typedef enum logic [2:0] {
        SEL_OUT,
        SEL_DIR,
        SEL_IN,
        SEL_IRQ_EN,
        SEL_IRQ_STAT,
        SEL_EDGE_SEL,
        SEL_NONE
    } reg_sel_e;

    // Byte address to register select; the two lowest address bits are ignored.
    function automatic reg_sel_e decode_reg(input logic [DATA_W-1:0] byte_addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        case (byte_addr & ~DATA_W'(3))
            OFF_OUT:      sel = SEL_OUT;
            OFF_DIR:      sel = SEL_DIR;
            OFF_IN:       sel = SEL_IN;
            OFF_IRQ_EN:   sel = SEL_IRQ_EN;
            OFF_IRQ_STAT: sel = SEL_IRQ_STAT;
            OFF_EDGE_SEL: sel = SEL_EDGE_SEL;
            default:      sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input channel: 2-flop synchroniser followed by a debounce filter that
// accepts a new level only after it has held for DEBOUNCE_CYCLES cycles.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    // High on the edge where dout is about to take the new synchronised level.
    assign changed = (sync != dout) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            if (sync == dout) begin
                cnt <= '0;
            end else if (changed) begin
                dout <= sync;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: output/direction registers, debounced inputs
// and edge-triggered interrupts with write-1-to-clear status.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH      = 10,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADDR_WIDTH      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam int SETTLE   = DEBOUNCE_CYCLES + 2;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    logic [GPIO_WIDTH-1:0] out_q;
    logic [GPIO_WIDTH-1:0] dir_q;
    logic [GPIO_WIDTH-1:0] ien_q;
    logic [GPIO_WIDTH-1:0] stat_q;
    logic [GPIO_WIDTH-1:0] esel_q;
    logic [GPIO_WIDTH-1:0] in_stable;
    logic [GPIO_WIDTH-1:0] changed;
    logic [GPIO_WIDTH-1:0] ev;
    logic [GPIO_WIDTH-1:0] w1c;
    logic [GPIO_WIDTH-1:0] wr_val;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic                  settled;
    logic [DATA_W-1:0]     rd_mux;
    reg_sel_e              sel;

    for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_ch
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .din    (gpio_i[g]),
            .dout   (in_stable[g]),
            .changed(changed[g])
        );
    end

    assign sel     = decode_reg(DATA_W'(addr));
    assign wr_val  = GPIO_WIDTH'(wdata);
    assign settled = (settle_cnt == SETTLE_W'(SETTLE));
    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;

    // A channel about to change moves away from its current stable value, so
    // a low stable value means the pending change is a rising edge.
    always_comb begin
        ev  = '0;
        w1c = '0;
        if (settled) begin
            ev = (changed & ~in_stable & esel_q) | (changed & in_stable & ~esel_q);
        end
        if (we && sel == SEL_IRQ_STAT) begin
            w1c = wr_val;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_OUT:      rd_mux[GPIO_WIDTH-1:0] = out_q;
            SEL_DIR:      rd_mux[GPIO_WIDTH-1:0] = dir_q;
            SEL_IN:       rd_mux[GPIO_WIDTH-1:0] = in_stable;
            SEL_IRQ_EN:   rd_mux[GPIO_WIDTH-1:0] = ien_q;
            SEL_IRQ_STAT: rd_mux[GPIO_WIDTH-1:0] = stat_q;
            SEL_EDGE_SEL: rd_mux[GPIO_WIDTH-1:0] = esel_q;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q      <= '0;
            dir_q      <= '0;
            ien_q      <= '0;
            stat_q     <= '0;
            esel_q     <= '0;
            settle_cnt <= '0;
            irq        <= 1'b0;
            rdata      <= '0;
            rvalid     <= 1'b0;
        end else begin
            if (!settled) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (we) begin
                case (sel)
                    SEL_OUT:      out_q  <= wr_val;
                    SEL_DIR:      dir_q  <= wr_val;
                    SEL_IRQ_EN:   ien_q  <= wr_val;
                    SEL_EDGE_SEL: esel_q <= wr_val;
                    default:      ;
                endcase
            end
            // New events are OR-ed in after the clear so set wins over W1C.
            stat_q <= (stat_q & ~w1c) | ev;
            irq    <= |(stat_q & ien_q);
            rvalid <= re;
            if (re) begin
                rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Randomised scoreboard bench for gpio_ctrl against a window-based reference model.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    localparam int W  = 10;
    localparam int D  = 16;
    localparam int AW = 5;
    localparam logic [31:0] MASK = 32'h3FF;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          rvalid;
    logic [W-1:0]  gpio_i = '0;
    logic [W-1:0]  gpio_o;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    logic [31:0] expq[$];
    logic [31:0] hist[$];
    logic [31:0] m_out = '0, m_dir = '0, m_in = '0, m_en = '0, m_stat = '0, m_esel = '0;
    logic        m_irq = 1'b0;
    int          n_edge = 0;

    gpio_ctrl #(
        .GPIO_WIDTH     (W),
        .DEBOUNCE_CYCLES(D),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .re     (re),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .gpio_i (gpio_i),
        .gpio_o (gpio_o),
        .gpio_oe(gpio_oe),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [AW-1:0] a);
        case (int'(a >> 2))
            0: return m_out;
            1: return m_dir;
            2: return m_in;
            3: return m_en;
            4: return m_stat;
            5: return m_esel;
            default: return 32'h0;
        endcase
    endfunction

    // Reference model: an input level is accepted once the synchronised pad
    // (two samples late) has shown the opposite level for D consecutive edges.
    always @(posedge clk) begin
        logic [31:0] nin, ev, w1c;
        logic        v;
        bit          all;
        if (!reset) begin
            m_out = '0; m_dir = '0; m_in = '0; m_en = '0; m_stat = '0; m_esel = '0;
            m_irq = 1'b0;
            n_edge = 0;
            hist.delete();
        end else begin
            n_edge++;
            hist.push_front(32'(gpio_i));
            if (hist.size() > D + 2) void'(hist.pop_back());
            if (re) expq.push_back(m_read(addr));
            nin = m_in;
            for (int b = 0; b < W; b++) begin
                all = 1'b1;
                for (int k = 2; k < D + 2; k++) begin
                    v = (k < hist.size()) ? hist[k][b] : 1'b0;
                    if (v == m_in[b]) all = 1'b0;
                end
                if (all) nin[b] = ~m_in[b];
            end
            ev = '0;
            if (n_edge >= D + 3)
                ev = ((nin & ~m_in & m_esel) | (~nin & m_in & ~m_esel)) & MASK;
            m_irq = |(m_stat & m_en);
            w1c = '0;
            if (we) begin
                case (int'(addr >> 2))
                    0: m_out  = wdata & MASK;
                    1: m_dir  = wdata & MASK;
                    3: m_en   = wdata & MASK;
                    4: w1c    = wdata & MASK;
                    5: m_esel = wdata & MASK;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~w1c) | ev;
            m_in = nin;
        end
    end

    // Monitor: pins every cycle, read data whenever rvalid is presented.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("gpio_o", 32'(gpio_o), m_out);
            chk("gpio_oe", 32'(gpio_oe), m_dir);
            chk("irq", 32'(irq), 32'(m_irq));
            if (rvalid) begin
                if (expq.size() == 0) begin
                    chk("rvalid_unexpected", 32'(rvalid), 32'h0);
                end else begin
                    chk("rdata", rdata, expq.pop_front());
                end
            end
        end
    end

    task automatic bus(input logic w, input logic r, input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        we = w; re = r; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int n);
        @(negedge clk);
        re = 1'b1; addr = a;
        repeat (n) @(negedge clk);
        re = 1'b0;
    endtask

    initial begin
        #1_000_000;
        chk("watchdog", 32'h1, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        gpio_i = '1;
        @(posedge clk);
        chk_on = 1'b1;
        idle(3);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) bus(1'b0, 1'b1, AW'(i * 4), 32'h0);
        idle(30);
        bus(1'b0, 1'b1, AW'(OFF_IRQ_STAT), 32'h0);

        bus(1'b1, 1'b0, AW'(OFF_DIR), 32'h3FF);
        bus(1'b1, 1'b0, AW'(OFF_OUT), 32'h155);
        bus(1'b0, 1'b1, AW'(OFF_OUT), 32'h0);
        bus(1'b1, 1'b1, AW'(OFF_OUT), 32'h2AA);
        bus(1'b0, 1'b1, AW'(OFF_OUT), 32'h0);

        @(negedge clk); gpio_i = '0;
        idle(25);
        bus(1'b1, 1'b0, AW'(OFF_IRQ_STAT), 32'hFFFF_FFFF);
        @(negedge clk); gpio_i[3] = 1'b1;
        idle(10);
        gpio_i[3] = 1'b0;
        read_burst(AW'(OFF_IN), 24);
        @(negedge clk); gpio_i[3] = 1'b1;
        read_burst(AW'(OFF_IN), 24);

        bus(1'b1, 1'b0, AW'(OFF_EDGE_SEL), 32'h1);
        bus(1'b1, 1'b0, AW'(OFF_IRQ_EN), 32'h1);
        bus(1'b1, 1'b0, AW'(OFF_IRQ_STAT), 32'h3FF);
        @(negedge clk); gpio_i[0] = 1'b1;
        idle(22);
        bus(1'b0, 1'b1, AW'(OFF_IRQ_STAT), 32'h0);
        @(negedge clk); gpio_i[0] = 1'b0;
        idle(22);
        bus(1'b0, 1'b1, AW'(OFF_IRQ_STAT), 32'h0);
        bus(1'b1, 1'b0, AW'(OFF_IRQ_STAT), 32'h1);
        idle(2);

        @(negedge clk); gpio_i[2] = 1'b1;
        idle(25);
        @(negedge clk); gpio_i[2] = 1'b0;
        idle(25);
        @(negedge clk); gpio_i[2] = 1'b1;
        idle(25);
        bus(1'b0, 1'b1, AW'(OFF_IRQ_STAT), 32'h0);
        // W1C lands on the same edge that accepts the falling level on channel 2.
        @(negedge clk); gpio_i[2] = 1'b0;
        repeat (16) @(negedge clk);
        bus(1'b1, 1'b0, AW'(OFF_IRQ_STAT), 32'h4);
        bus(1'b0, 1'b1, AW'(OFF_IRQ_STAT), 32'h0);

        bus(1'b1, 1'b0, AW'(OFF_IRQ_EN), 32'hFFFF_FFFF);
        bus(1'b0, 1'b1, AW'(OFF_IRQ_EN), 32'h0);
        bus(1'b1, 1'b0, AW'(5'h18), 32'hFFFF_FFFF);
        bus(1'b0, 1'b1, AW'(5'h1C), 32'h0);
        bus(1'b0, 1'b1, AW'(5'h18), 32'h0);

        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            we = 1'b0; re = 1'b0;
            if ($urandom_range(0, 5) == 0) gpio_i = gpio_i ^ W'(1 << $urandom_range(0, W - 1));
            addr = AW'($urandom);
            wdata = $urandom;
            case ($urandom_range(0, 3))
                0: we = 1'b1;
                1: re = 1'b1;
                2: begin we = 1'b1; re = 1'b1; end
                default: ;
            endcase
        end
        @(negedge clk); we = 1'b0; re = 1'b0;
        idle(40);
        for (int i = 0; i < 6; i++) bus(1'b0, 1'b1, AW'(i * 4), 32'h0);
        idle(4);
        chk("pending_reads", 32'(expq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
